// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter with a one-entry holding register
// and a running byte sum in the same form the receiver reports.
module uart_tx #(
    parameter int cycles_per_bit  = 4,
    parameter int extra_stop_bits = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  i_data,
    input  logic        i_req,
    output logic        o_serial,
    output logic        o_cts,
    output logic        o_idle,
    output logic [31:0] o_sum
);

    localparam int CW = (cycles_per_bit > 1) ? $clog2(cycles_per_bit) : 1;
    localparam logic [CW-1:0] CYC_LAST  = CW'(cycles_per_bit - 1);
    localparam logic [CW-1:0] CYC_ONE   = CW'(1);
    localparam logic [3:0]    STOP_LAST = 4'(extra_stop_bits);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cyc, cyc_n;
    logic [3:0]    bit_cnt, bit_cnt_n;
    logic [7:0]    shift, shift_n;
    logic [7:0]    hold;
    logic          hold_valid, hold_valid_n;
    logic [31:0]   sum, sum_n;
    logic          serial, line;
    logic          accept, direct, hold_wr, hold_mv, tick;

    always_comb begin
        tick      = (cyc == '0);
        accept    = i_req && !hold_valid;
        direct    = accept && (state == IDLE);
        hold_wr   = accept && !direct;
        hold_mv   = 1'b0;
        state_n   = state;
        cyc_n     = cyc;
        bit_cnt_n = bit_cnt;
        shift_n   = shift;
        sum_n     = sum;
        line      = 1'b1;
        unique case (state)
            IDLE: begin
                if (direct) begin
                    shift_n = i_data;
                    sum_n   = sum + 32'(i_data);
                    cyc_n   = CYC_LAST;
                    state_n = START;
                end
            end
            START: begin
                line = 1'b0;
                if (tick) begin
                    cyc_n     = CYC_LAST;
                    bit_cnt_n = '0;
                    state_n   = DATA;
                end else begin
                    cyc_n = cyc - CYC_ONE;
                end
            end
            DATA: begin
                line = shift[0];
                if (tick) begin
                    cyc_n   = CYC_LAST;
                    shift_n = {1'b0, shift[7:1]};
                    if (bit_cnt == 4'd7) begin
                        bit_cnt_n = '0;
                        state_n   = STOP;
                    end else begin
                        bit_cnt_n = bit_cnt + 4'd1;
                    end
                end else begin
                    cyc_n = cyc - CYC_ONE;
                end
            end
            STOP: begin
                line = 1'b1;
                if (tick) begin
                    cyc_n = CYC_LAST;
                    if (bit_cnt == STOP_LAST) begin
                        bit_cnt_n = '0;
                        // Held byte chains straight into the next start bit.
                        if (hold_valid) begin
                            hold_mv = 1'b1;
                            shift_n = hold;
                            sum_n   = sum + 32'(hold);
                            state_n = START;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        bit_cnt_n = bit_cnt + 4'd1;
                    end
                end else begin
                    cyc_n = cyc - CYC_ONE;
                end
            end
            default: state_n = IDLE;
        endcase
        hold_valid_n = hold_wr || (hold_valid && !hold_mv);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cyc        <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            hold       <= '0;
            hold_valid <= 1'b0;
            sum        <= '0;
            serial     <= 1'b1;
        end else begin
            state      <= state_n;
            cyc        <= cyc_n;
            bit_cnt    <= bit_cnt_n;
            shift      <= shift_n;
            hold_valid <= hold_valid_n;
            sum        <= sum_n;
            serial     <= line;
            if (hold_wr) begin
                hold <= i_data;
            end
        end
    end

    assign o_serial = serial;
    assign o_cts    = !hold_valid;
    assign o_idle   = (state == IDLE) && !hold_valid;
    assign o_sum    = sum;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scenario tasks against a frame-level model of 8N1
// transmission; dut1 carries two extra stop bits.
module tb_uart_tx;

    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  data0, data1;
    logic        req0, req1;
    logic        ser0, cts0, idle0;
    logic        ser1, cts1, idle1;
    logic [31:0] sum0, sum1;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    uart_tx #(.cycles_per_bit(CPB), .extra_stop_bits(0)) dut0 (
        .clk(clk), .rst(rst), .i_data(data0), .i_req(req0),
        .o_serial(ser0), .o_cts(cts0), .o_idle(idle0), .o_sum(sum0)
    );

    uart_tx #(.cycles_per_bit(CPB), .extra_stop_bits(2)) dut1 (
        .clk(clk), .rst(rst), .i_data(data1), .i_req(req1),
        .o_serial(ser1), .o_cts(cts1), .o_idle(idle1), .o_sum(sum1)
    );

    // Line monitor for dut0: collects whole frames and decodes them.
    logic [7:0] rx_q[$];
    int         rx_t[$];
    logic [7:0] acc_q[$];
    logic       smp[$];
    int         ferr;
    int         t0;

    always @(negedge clk) begin
        if (rst) begin
            smp.delete();
            rx_q.delete();
            rx_t.delete();
            acc_q.delete();
            ferr = 0;
        end else begin
            logic       fb;
            logic [7:0] b;
            if (req0 && cts0) acc_q.push_back(data0);
            if (smp.size() > 0 || ser0 === 1'b0) begin
                if (smp.size() == 0) t0 = cyc_cnt;
                smp.push_back(ser0);
                if (smp.size() == 10 * CPB) begin
                    fb = 1'b1;
                    b  = '0;
                    for (int i = 0; i < 10 * CPB; i++)
                        if (smp[i] !== smp[(i / CPB) * CPB]) fb = 1'b0;
                    if (smp[0] !== 1'b0 || smp[9 * CPB] !== 1'b1) fb = 1'b0;
                    for (int i = 0; i < 8; i++) b[i] = smp[(i + 1) * CPB];
                    if (!fb) ferr++;
                    rx_q.push_back(b);
                    rx_t.push_back(t0);
                    smp.delete();
                end
            end
        end
    end

    // Level of bit period p of a frame carrying byte b.
    function automatic logic frame_bit(input logic [7:0] b, input int p);
        if (p == 0) return 1'b0;
        if (p <= 8) return b[p - 1];
        return 1'b1;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_idle0(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (idle0 && ser0) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    logic [7:0] feed_q[$];
    int         acc_k[$];

    // Holds i_req high, advancing i_data after every accepting edge.
    task automatic feed0(output bit ok);
        int idx = 0;
        int k = 0;
        bit acc;
        acc_k.delete();
        req0 = 1'b1;
        data0 = feed_q[0];
        while (idx < feed_q.size() && k < 50 * feed_q.size() + 100) begin
            @(negedge clk);
            acc = cts0;
            @(posedge clk);
            #1;
            if (acc) begin
                acc_k.push_back(k);
                idx++;
                if (idx < feed_q.size()) data0 = feed_q[idx];
            end
            k++;
        end
        req0 = 1'b0;
        ok = (idx == feed_q.size());
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req0 = 1'b0;
        req1 = 1'b0;
        data0 = '0;
        data1 = '0;
        @(posedge clk);
        #1;
        n_tests++;
        if (ser0 !== 1'b1 || ser1 !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_serial got %b/%b want 1/1", ser0, ser1);
        end
        n_tests++;
        if (cts0 !== 1'b1 || idle0 !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_cts_idle got %b/%b want 1/1", cts0, idle0);
        end
        n_tests++;
        if (sum0 !== 32'd0 || sum1 !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_sum got %h/%h want 0", sum0, sum1);
        end
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (ser0 !== 1'b1 || idle0 !== 1'b1 || cts1 !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release got ser=%b idle=%b cts1=%b want 1",
                     ser0, idle0, cts1);
        end
    endtask

    task automatic test_single();
        logic [7:0] b = 8'h55;
        int  bad = 0;
        logic idle_39, idle_40;
        do_reset();
        req0 = 1'b1;
        data0 = b;
        @(posedge clk);
        #1;
        req0 = 1'b0;
        data0 = 8'($urandom);
        for (int k = 0; k <= 42; k++) begin
            @(negedge clk);
            if (ser0 !== ((k == 0) ? 1'b1 : frame_bit(b, (k - 1) / CPB))) bad++;
            if (k == 39) idle_39 = idle0;
            if (k == 40) idle_40 = idle0;
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL single_wave got %0d bad clocks want 0", bad);
        end
        n_tests++;
        if (idle_39 !== 1'b0 || idle_40 !== 1'b1) begin
            n_fail++;
            $display("FAIL single_idle got %b%b want 01", idle_39, idle_40);
        end
        n_tests++;
        if (sum0 !== 32'h55) begin
            n_fail++;
            $display("FAIL single_sum got %h want 55", sum0);
        end
        n_tests++;
        if (rx_q.size() != 1 || rx_q[0] !== b) begin
            n_fail++;
            $display("FAIL single_rx got %0d frames want 1 of 55", rx_q.size());
        end
    endtask

    task automatic test_back_to_back();
        bit ok, idle_ok;
        int bad = 0;
        int want_k[3] = '{0, 1, 41};
        logic [7:0] want[3] = '{8'h01, 8'h80, 8'hFF};
        do_reset();
        feed_q = '{8'h01, 8'h80, 8'hFF};
        feed0(ok);
        wait_idle0(idle_ok);
        n_tests++;
        if (!ok || !idle_ok) begin
            n_fail++;
            $display("FAIL b2b_timeout got feed=%b idle=%b want 1/1", ok, idle_ok);
        end
        for (int i = 0; i < 3; i++)
            if (i >= acc_k.size() || acc_k[i] != want_k[i]) bad++;
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL b2b_cts_edges got %0d wrong accept edges want 0", bad);
        end
        bad = 0;
        for (int i = 0; i < 3; i++)
            if (i >= rx_q.size() || rx_q[i] !== want[i]) bad++;
        n_tests++;
        if (bad != 0 || rx_q.size() != 3 || ferr != 0) begin
            n_fail++;
            $display("FAIL b2b_rx got %0d frames %0d wrong %0d framing want 3/0/0",
                     rx_q.size(), bad, ferr);
        end
        n_tests++;
        if (rx_t.size() != 3 || rx_t[1] - rx_t[0] != 40 || rx_t[2] - rx_t[1] != 40) begin
            n_fail++;
            $display("FAIL b2b_gap got %0d frames with nonzero idle want contiguous",
                     rx_t.size());
        end
        n_tests++;
        if (sum0 !== 32'h180) begin
            n_fail++;
            $display("FAIL b2b_sum got %h want 180", sum0);
        end
    endtask

    task automatic test_cts_block();
        bit ok, idle_ok;
        int blk = 0;
        do_reset();
        feed_q = '{8'h11, 8'h22};
        feed0(ok);
        req0 = 1'b1;
        data0 = 8'hAA;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (cts0 !== 1'b0) blk++;
            @(posedge clk);
            #1;
        end
        req0 = 1'b0;
        wait_idle0(idle_ok);
        n_tests++;
        if (!ok || !idle_ok || blk != 0) begin
            n_fail++;
            $display("FAIL block_cts got %0d open clocks feed=%b idle=%b want 0/1/1",
                     blk, ok, idle_ok);
        end
        n_tests++;
        if (rx_q.size() != 2 || rx_q[0] !== 8'h11 || rx_q[1] !== 8'h22) begin
            n_fail++;
            $display("FAIL block_rx got %0d frames want 11,22", rx_q.size());
        end
        n_tests++;
        if (sum0 !== 32'h33) begin
            n_fail++;
            $display("FAIL block_sum got %h want 33", sum0);
        end
    endtask

    task automatic test_reset_mid();
        int at_q[2] = '{17, 2};
        for (int r = 0; r < 2; r++) begin
            int lows = 0;
            do_reset();
            req0 = 1'b1;
            data0 = 8'h3C;
            @(posedge clk);
            #1 data0 = 8'h5A;
            @(posedge clk);
            #1 req0 = 1'b0;
            repeat (at_q[r] - 1) @(posedge clk);
            #1 rst = 1'b1;
            #1;
            n_tests++;
            if (ser0 !== 1'b1 || idle0 !== 1'b1 || cts0 !== 1'b1 || sum0 !== 32'd0) begin
                n_fail++;
                $display("FAIL rstmid_async at %0d got ser=%b idle=%b cts=%b sum=%h want 1/1/1/0",
                         at_q[r], ser0, idle0, cts0, sum0);
            end
            repeat (2) @(posedge clk);
            #1 rst = 1'b0;
            for (int i = 0; i < 60; i++) begin
                @(negedge clk);
                if (ser0 !== 1'b1) lows++;
            end
            @(posedge clk);
            #1;
            n_tests++;
            if (lows != 0 || rx_q.size() != 0 || idle0 !== 1'b1 || sum0 !== 32'd0) begin
                n_fail++;
                $display("FAIL rstmid_after at %0d got lows=%0d frames=%0d sum=%h want 0/0/0",
                         at_q[r], lows, rx_q.size(), sum0);
            end
        end
    endtask

    task automatic test_extra_stop();
        logic [7:0] b[2];
        int   bad = 0;
        logic idle_95, idle_96;
        do_reset();
        b[0] = 8'($urandom);
        b[1] = 8'($urandom);
        req1 = 1'b1;
        data1 = b[0];
        @(posedge clk);
        #1 data1 = b[1];
        @(posedge clk);
        #1 req1 = 1'b0;
        // Next negedge follows the second edge after acceptance.
        for (int k = 1; k <= 100; k++) begin
            logic e;
            @(negedge clk);
            if (k > 96) e = 1'b1;
            else e = frame_bit(b[(k - 1) / 48], ((k - 1) % 48) / CPB);
            if (ser1 !== e) bad++;
            if (k == 95) idle_95 = idle1;
            if (k == 96) idle_96 = idle1;
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL xstop_wave got %0d bad clocks want 0", bad);
        end
        n_tests++;
        if (idle_95 !== 1'b0 || idle_96 !== 1'b1) begin
            n_fail++;
            $display("FAIL xstop_idle got %b%b want 01", idle_95, idle_96);
        end
        n_tests++;
        if (sum1 !== 32'(b[0]) + 32'(b[1])) begin
            n_fail++;
            $display("FAIL xstop_sum got %h want %h", sum1, 32'(b[0]) + 32'(b[1]));
        end
    endtask

    task automatic test_random();
        bit idle_ok;
        int bad = 0;
        logic [31:0] s = '0;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            req0 = 1'($urandom_range(0, 1));
            data0 = 8'($urandom);
            @(posedge clk);
            #1;
        end
        req0 = 1'b0;
        wait_idle0(idle_ok);
        for (int i = 0; i < acc_q.size(); i++) begin
            s += 32'(acc_q[i]);
            if (i >= rx_q.size() || rx_q[i] !== acc_q[i]) bad++;
        end
        n_tests++;
        if (!idle_ok || bad != 0 || rx_q.size() != acc_q.size() || ferr != 0) begin
            n_fail++;
            $display("FAIL rand_stream got %0d frames %0d wrong %0d framing want %0d/0/0",
                     rx_q.size(), bad, ferr, acc_q.size());
        end
        n_tests++;
        if (sum0 !== s) begin
            n_fail++;
            $display("FAIL rand_sum got %h want %h", sum0, s);
        end
    endtask

    task automatic test_all_bytes();
        bit ok, idle_ok;
        int bad = 0;
        int badk = 0;
        int badt = 0;
        do_reset();
        feed_q.delete();
        for (int i = 0; i < 256; i++) feed_q.push_back(8'(i));
        feed0(ok);
        wait_idle0(idle_ok);
        for (int i = 0; i < 256; i++) begin
            if (i >= rx_q.size() || rx_q[i] !== 8'(i)) bad++;
            if (i >= acc_k.size() || acc_k[i] != ((i < 2) ? i : 40 * (i - 1) + 1)) badk++;
            if (i > 0 && (i >= rx_t.size() || rx_t[i] - rx_t[i - 1] != 40)) badt++;
        end
        n_tests++;
        if (!ok || !idle_ok || bad != 0 || rx_q.size() != 256 || ferr != 0) begin
            n_fail++;
            $display("FAIL all_rx got %0d frames %0d wrong %0d framing want 256/0/0",
                     rx_q.size(), bad, ferr);
        end
        n_tests++;
        if (badk != 0 || badt != 0) begin
            n_fail++;
            $display("FAIL all_timing got %0d accept %0d gap errors want 0/0", badk, badt);
        end
        n_tests++;
        if (sum0 !== 32'h7F80) begin
            n_fail++;
            $display("FAIL all_sum got %h want 7f80", sum0);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_cts_block();
        test_reset_mid();
        test_extra_stop();
        test_random();
        test_all_bytes();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
